led_fade: RTL and testbench

Downstream stage of `flow_led`. It takes the two-bit on/off LED pattern and drives the physical LEDs with PWM, so each LED fades smoothly toward its commanded state instead of switching hard. Every channel has a saturating duty register that steps up or down at a fixed rate, and a shared free-running PWM counter. All logic runs in the `sys_clk` domain with no clock-domain crossing.

---
 rtl/led_fade_if.sv | 10 +
 rtl/led_fade.sv | 67 ++++++
 tb/tb_led_fade.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/led_fade_if.sv
// LED command/drive bundle between flow_led and the PWM fader.
// The master drives led_in; the slave (led_fade) returns led_out and busy.
interface led_fade_if;
    logic [1:0] led_in;
    logic [1:0] led_out;
    logic [1:0] busy;

    modport master (output led_in, input led_out, input busy);
    modport slave  (input led_in, output led_out, output busy);
endinterface

// File: rtl/led_fade.sv
// Two-channel LED fader: saturating per-channel duty ramps toward the commanded
// state at a prescaled rate, and a shared free-running counter turns duty into PWM.
module led_fade #(
    parameter int unsigned PWM_W    = 8,
    parameter logic [24:0] STEP_MAX = 25'd196_078
) (
    input logic        sys_clk,
    input logic        sys_rst,
    led_fade_if.slave  bus
);
    localparam logic [PWM_W-1:0] DutyMax  = {PWM_W{1'b1}};
    localparam logic [PWM_W-1:0] PwmOne   = PWM_W'(1);
    localparam logic [24:0]      StepLast = STEP_MAX - 25'd1;

    logic [1:0]             led_q, led_d;
    logic [24:0]            step_cnt_q, step_cnt_d;
    logic [PWM_W-1:0]       pwm_cnt_q, pwm_cnt_d;
    logic [1:0][PWM_W-1:0]  duty_q, duty_d;
    logic [1:0]             led_out_q, led_out_d;
    logic                   step_tick;

    always_comb begin
        step_tick  = (step_cnt_q == StepLast);
        step_cnt_d = step_tick ? 25'd0 : step_cnt_q + 25'd1;
        pwm_cnt_d  = pwm_cnt_q + PwmOne;
        led_d      = bus.led_in;
        duty_d     = duty_q;
        led_out_d  = '0;
        for (int i = 0; i < 2; i++) begin
            // Decisions use the sampled command so both channels see one coherent value.
            if (step_tick) begin
                if (led_q[i] && (duty_q[i] != DutyMax)) begin
                    duty_d[i] = duty_q[i] + PwmOne;
                end else if (!led_q[i] && (duty_q[i] != '0)) begin
                    duty_d[i] = duty_q[i] - PwmOne;
                end
            end
            // Full scale is forced high so MAX means constantly lit, not MAX/(MAX+1).
            led_out_d[i] = (duty_q[i] == DutyMax) | (pwm_cnt_q < duty_q[i]);
        end
    end

    always_comb begin
        bus.busy = '0;
        for (int i = 0; i < 2; i++) begin
            bus.busy[i] = led_q[i] ? (duty_q[i] != DutyMax) : (duty_q[i] != '0);
        end
    end

    assign bus.led_out = led_out_q;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            led_q      <= '0;
            step_cnt_q <= '0;
            pwm_cnt_q  <= '0;
            duty_q     <= '0;
            led_out_q  <= '0;
        end else begin
            led_q      <= led_d;
            step_cnt_q <= step_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
            duty_q     <= duty_d;
            led_out_q  <= led_out_d;
        end
    end
endmodule

// File: tb/tb_led_fade.sv
// Directed bench for led_fade: DUT a runs STEP_MAX=4, DUT b runs STEP_MAX=64 for PWM ratio.
module tb_led_fade;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    led_fade_if bus_a ();
    led_fade_if bus_b ();

    led_fade #(.PWM_W(4), .STEP_MAX(25'd4)) dut_a (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus_a)
    );

    led_fade #(.PWM_W(4), .STEP_MAX(25'd64)) dut_b (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench #1 after the last reset edge: all registers zero.
    task automatic do_reset(input int n);
        rst = 1'b0;
        repeat (n) step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        bus_a.led_in = 2'b11;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            n_tests++;
            if (bus_a.led_out !== 2'b00 || bus_a.busy !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_hold cyc %0d: led_out=%b busy=%b, want 00 00",
                         c, bus_a.led_out, bus_a.busy);
            end
        end
        rst = 1'b1;
        step();
        step();
        n_tests++;
        if (bus_a.busy !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_release_busy: busy=%b, want 11", bus_a.busy);
        end
    endtask

    task automatic test_fade_up();
        logic [3:0] exp_duty;
        bus_a.led_in = 2'b01;
        do_reset(2);
        for (int k = 1; k <= 70; k++) begin
            step();
            exp_duty = (k / 4 >= 15) ? 4'd15 : 4'(k / 4);
            n_tests++;
            if (dut_a.duty_q[0] !== exp_duty) begin
                n_fail++;
                $display("FAIL fade_up_duty edge %0d: duty0=%0d, want %0d",
                         k, dut_a.duty_q[0], exp_duty);
            end
            n_tests++;
            if (bus_a.busy[0] !== (exp_duty != 4'd15)) begin
                n_fail++;
                $display("FAIL fade_up_busy0 edge %0d: busy0=%b, want %b",
                         k, bus_a.busy[0], exp_duty != 4'd15);
            end
            n_tests++;
            if (bus_a.led_out[1] !== 1'b0 || bus_a.busy[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL fade_up_ch1 edge %0d: led_out1=%b busy1=%b, want 0 0",
                         k, bus_a.led_out[1], bus_a.busy[1]);
            end
            if (k >= 61) begin
                n_tests++;
                if (bus_a.led_out[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL fade_up_full edge %0d: led_out0=%b, want 1",
                             k, bus_a.led_out[0]);
                end
            end
        end
    endtask

    task automatic test_reversal();
        int         d;
        logic [3:0] exp_duty;
        bus_a.led_in = 2'b01;
        do_reset(2);
        repeat (24) step();
        n_tests++;
        if (dut_a.duty_q[0] !== 4'd6) begin
            n_fail++;
            $display("FAIL reversal_start: duty0=%0d, want 6", dut_a.duty_q[0]);
        end
        bus_a.led_in = 2'b00;
        for (int k = 25; k <= 80; k++) begin
            step();
            d = 6 - (k - 24) / 4;
            exp_duty = (d < 0) ? 4'd0 : 4'(d);
            n_tests++;
            if (dut_a.duty_q[0] !== exp_duty) begin
                n_fail++;
                $display("FAIL reversal_duty edge %0d: duty0=%0d, want %0d",
                         k, dut_a.duty_q[0], exp_duty);
            end
            n_tests++;
            if (bus_a.busy[0] !== (exp_duty != 4'd0)) begin
                n_fail++;
                $display("FAIL reversal_busy0 edge %0d: busy0=%b, want %b",
                         k, bus_a.busy[0], exp_duty != 4'd0);
            end
        end
    endtask

    task automatic test_pwm_ratio();
        int e;
        int cnt;
        int exp_cnt;
        bus_b.led_in = 2'b10;
        do_reset(2);
        e = 0;
        for (int j = 0; j < 16; j++) begin
            // duty1 is j over edges 64j..64j+63; window pwm_cnt 0..15 starts after edge 64j+16.
            while (e < 64 * j + 16) begin
                step();
                e++;
            end
            cnt = 0;
            repeat (16) begin
                step();
                e++;
                if (bus_b.led_out[1] === 1'b1) cnt++;
            end
            exp_cnt = (j == 15) ? 16 : j;
            n_tests++;
            if (cnt !== exp_cnt) begin
                n_fail++;
                $display("FAIL pwm_ratio duty %0d: high cycles=%0d, want %0d", j, cnt, exp_cnt);
            end
        end
        bus_b.led_in = 2'b00;
    endtask

    task automatic test_saturation();
        bus_a.led_in = 2'b11;
        do_reset(2);
        repeat (60) step();
        for (int k = 61; k <= 460; k++) begin
            step();
            n_tests++;
            if (bus_a.led_out !== 2'b11 || dut_a.duty_q[0] !== 4'd15
                || dut_a.duty_q[1] !== 4'd15) begin
                n_fail++;
                $display("FAIL saturation edge %0d: led_out=%b duty0=%0d duty1=%0d, want 11 15 15",
                         k, bus_a.led_out, dut_a.duty_q[0], dut_a.duty_q[1]);
            end
        end
    endtask

    task automatic test_reset_mid_fade();
        bus_a.led_in = 2'b01;
        do_reset(2);
        repeat (36) step();
        n_tests++;
        if (dut_a.duty_q[0] !== 4'd9) begin
            n_fail++;
            $display("FAIL mid_fade_pre: duty0=%0d, want 9", dut_a.duty_q[0]);
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        n_tests++;
        if (dut_a.duty_q[0] !== 4'd0 || bus_a.led_out !== 2'b00
            || dut_a.step_cnt_q !== 25'd0 || dut_a.pwm_cnt_q !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_fade_reset: duty0=%0d led_out=%b step=%0d pwm=%0d, want 0 00 0 0",
                     dut_a.duty_q[0], bus_a.led_out, dut_a.step_cnt_q, dut_a.pwm_cnt_q);
        end
        repeat (3) step();
        n_tests++;
        if (dut_a.duty_q[0] !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_fade_pretick: duty0=%0d, want 0", dut_a.duty_q[0]);
        end
        step();
        n_tests++;
        if (dut_a.duty_q[0] !== 4'd1) begin
            n_fail++;
            $display("FAIL mid_fade_restart: duty0=%0d, want 1", dut_a.duty_q[0]);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0;
        bus_a.led_in = 2'b00;
        bus_b.led_in = 2'b00;
        test_reset();
        test_fade_up();
        test_reversal();
        test_pwm_ratio();
        test_saturation();
        test_reset_mid_fade();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
